// File: rtl/vlsu_cam_pkg.sv
// Shared constants and types for the CAM slice (vlsu_cam_top, its allocation
// controller and the benches that drive them).
package vlsu_cam_pkg;

  localparam int WIDTH   = 50;
  localparam int DEPTH   = 32;
  localparam int READ    = 3;
  localparam int ADDRESS = $clog2(DEPTH);

  typedef logic [WIDTH-1:0]   width_t;
  typedef logic [ADDRESS-1:0] addr_t;
  typedef logic [DEPTH-1:0]   depth_t;
  // Entry index plus one wrap bit in the MSB.
  typedef logic [ADDRESS:0]   ptr_t;

endpackage

// File: rtl/vlsu_cam_ptr.sv
// Wrap-bit circular pointer. The low ADDRESS bits index an entry and the MSB
// toggles every time the index wraps DEPTH-1 -> 0, so two pointers with equal
// index and different wrap bits describe a full queue. DEPTH is a power of two,
// so a plain binary increment performs both the wrap and the toggle.
module vlsu_cam_ptr #(
  parameter int ADDRESS = 5
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [ADDRESS:0] ptr_o
);

  localparam logic [ADDRESS:0] PTR_ONE = {{ADDRESS{1'b0}}, 1'b1};

  // Pointer register: clear has priority over increment.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: state is written with <= so every flop samples pre-edge values;
    // a blocking = here would let later logic in the same block see the new value.
    if (!arst_n) begin
      ptr_o <= '0;
    end else if (clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= ptr_o + PTR_ONE;
    end
  end

endmodule

// File: rtl/vlsu_cam_alloc_ctrl.sv
// Allocation/retire controller in front of vlsu_cam_top. Entries form an
// age-ordered circular queue: tail hands out indices to new entries, head points
// at the oldest one. A new entry's data reaches the CAM write port one cycle
// after it is accepted, and the entry becomes visible to the compare ports
// (through its valid bit) on the edge where that write is captured.
module vlsu_cam_alloc_ctrl
  import vlsu_cam_pkg::*;
#(
  parameter int WIDTH = vlsu_cam_pkg::WIDTH,
  parameter int DEPTH = vlsu_cam_pkg::DEPTH,
  parameter int READ  = vlsu_cam_pkg::READ
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          flush_i,
  input  logic                          alloc_valid_i,
  input  logic [WIDTH-1:0]              alloc_data_i,
  output logic                          alloc_ready_o,
  output logic [$clog2(DEPTH)-1:0]      alloc_addr_o,
  input  logic                          retire_i,
  output logic                          retire_ready_o,
  output logic                          write_o,
  output logic [$clog2(DEPTH)-1:0]      write_addr_o,
  output logic [WIDTH-1:0]              write_data_o,
  output logic [$clog2(DEPTH)-1:0]      head_o,
  output logic [READ*DEPTH-1:0]         enable_o,
  output logic                          clear_o,
  output logic [$clog2(DEPTH)-1:0]      clear_addr_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int ADDRESS = $clog2(DEPTH);

  logic [ADDRESS:0]   head_ptr;
  logic [ADDRESS:0]   tail_ptr;
  logic [ADDRESS-1:0] head_idx;
  logic [ADDRESS-1:0] tail_idx;

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;

  logic               write_q;
  logic [ADDRESS-1:0] write_addr_q;
  logic [WIDTH-1:0]   write_data_q;
  logic               clear_q;
  logic [ADDRESS-1:0] clear_addr_q;

  logic               full;
  logic               empty;
  logic               alloc_ready;
  logic               alloc_fire;
  logic               retire_ready;
  logic               retire_fire;

  // ---------------------------------------------------------------------------
  // Queue status, decoded straight from the pointer registers.
  // ---------------------------------------------------------------------------
  assign head_idx = head_ptr[ADDRESS-1:0];
  assign tail_idx = tail_ptr[ADDRESS-1:0];

  assign full  = (head_idx == tail_idx) && (head_ptr[ADDRESS] != tail_ptr[ADDRESS]);
  assign empty = (head_ptr == tail_ptr);

  // Ready looks only at full, never at retire_i: a slot freed this cycle is
  // offered no earlier than the next cycle. Flush also blocks acceptance.
  assign alloc_ready  = !full && !flush_i;
  assign alloc_fire   = alloc_valid_i && alloc_ready;

  // The oldest entry can only leave once its write has landed in the CAM.
  assign retire_ready = valid_q[head_idx];
  assign retire_fire  = retire_i && retire_ready && !flush_i;

  // ---------------------------------------------------------------------------
  // Head and tail pointers; flush returns both to zero.
  // ---------------------------------------------------------------------------
  vlsu_cam_ptr #(
    .ADDRESS (ADDRESS)
  ) u_head_ptr (
    .clk    (clk),
    .arst_n (arst_n),
    .inc_i  (retire_fire),
    .clr_i  (flush_i),
    .ptr_o  (head_ptr)
  );

  vlsu_cam_ptr #(
    .ADDRESS (ADDRESS)
  ) u_tail_ptr (
    .clk    (clk),
    .arst_n (arst_n),
    .inc_i  (alloc_fire),
    .clr_i  (flush_i),
    .ptr_o  (tail_ptr)
  );

  // ---------------------------------------------------------------------------
  // Valid bits: set when the CAM captures an entry, cleared when it retires.
  // A retiring entry is always already valid and a pending write always targets
  // a slot that is not, so set and clear never hit the same bit on one edge.
  // ---------------------------------------------------------------------------

  // Next-state of the valid mask.
  always_comb begin
    // NOTE: valid_d takes a full default before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    valid_d = valid_q;
    if (write_q) begin
      valid_d[write_addr_q] = 1'b1;
    end
    if (retire_fire) begin
      valid_d[head_idx] = 1'b0;
    end
  end

  // Valid mask register; flush drops every entry including a pending write.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: this flop array is small and its reset value is functionally
    // required (empty queue), so unlike a data RAM it does take the reset.
    if (!arst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CAM write port: one registered write per accepted entry.
  // ---------------------------------------------------------------------------

  // Write strobe, address and data, launched the edge after acceptance.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      write_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      // alloc_fire is already low during flush, which cancels any new write.
      write_q <= alloc_fire;
      if (alloc_fire) begin
        write_addr_q <= tail_idx;
        write_data_q <= alloc_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Clear pulse: reports the index freed by each retire.
  // ---------------------------------------------------------------------------

  // One-cycle clear strobe carrying the old head index.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      clear_q      <= 1'b0;
      clear_addr_q <= '0;
    end else begin
      clear_q <= retire_fire;
      if (retire_fire) begin
        clear_addr_q <= head_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign alloc_ready_o  = alloc_ready;
  assign alloc_addr_o   = tail_idx;
  assign retire_ready_o = retire_ready;

  assign write_o        = write_q;
  assign write_addr_o   = write_addr_q;
  assign write_data_o   = write_data_q;

  assign clear_o        = clear_q;
  assign clear_addr_o   = clear_addr_q;

  assign head_o         = head_idx;
  // Modular pointer difference; the wrap bit makes DEPTH representable.
  assign count_o        = tail_ptr - head_ptr;
  assign full_o         = full;
  assign empty_o        = empty;

  // Every compare port searches exactly the set of live entries.
  assign enable_o       = {READ{valid_q}};

endmodule
